core_bus_slave: RTL and testbench
=================================

CORE_BUS_SLAVE -- requirements
Module: core_bus_slave

Interface
REQ-001 Parameter: ID_VALUE, 32'hC0DE_0001, constant returned at ID register.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 Port: address  in  3  word address of bus access.
REQ-005 Port: read  in  1  bus read strobe, one access per cycle asserted.
REQ-006 Port: write  in  1  bus write strobe, one access per cycle asserted.
REQ-007 Port: writeData  in  32  bus write data.
REQ-008 Port: byteEnable  in  4  per-byte write qualifier, bit n = writeData[8n+7:8n].
REQ-009 Port: readData  out  32  registered read data.
REQ-010 Port: readDataValid  out  1  one-cycle pulse qualifying readData.
REQ-011 Port: irqOut  out  1  registered interrupt to host.
REQ-012 Port: coreCounter1In, coreCounter2In  out  32 each  load values to the counter core.
REQ-013 Port: coreCounter1We, coreCounter2We, coreCounter1Re, coreCounter2Re  out  1 each  core write/read enables.
REQ-014 Port: coreCounter1, coreCounter2  in  32 each  live core counter values.
REQ-015 Port: coreIrq  in  1  level interrupt from the counter core.

Function
REQ-016 Map SHALL be: 0 COUNTER1 (RW), 1 COUNTER2 (RW), 2 IRQ_STATUS (R/W1C, bit0 only), 3 IRQ_ENABLE (RW, bit0 only), 4 ID (RO); 5-7 reserved.
REQ-017 Write to 0/1 SHALL, combinationally in the same cycle, assert coreCounterNWe for exactly that cycle with coreCounterNIn = byte merge: enabled bytes from writeData, others from current coreCounterN.
REQ-018 Write with byteEnable = 0 to 0/1 SHALL still pulse coreCounterNWe (loads current value, net effect: counter holds one cycle).
REQ-019 Read of 0/1 SHALL pulse coreCounterNRe the same cycle and capture coreCounterN into readData at that clock edge.
REQ-020 Every accepted read SHALL produce readDataValid = 1 exactly one cycle later; read latency fixed at 1, no wait states, back-to-back reads every cycle allowed.
REQ-021 Reads of reserved addresses SHALL return 0 with readDataValid; writes to reserved or ID SHALL be ignored.
REQ-022 read and write asserted together SHALL be treated as write only; no readDataValid, no Re pulse.
REQ-023 readData SHALL hold its last value when readDataValid = 0.
REQ-024 Block SHALL register coreIrq (coreIrqQ) and set IRQ_STATUS bit0 on rising edge (coreIrq = 1, coreIrqQ = 0).
REQ-025 Write with writeData[0] = 1 and byteEnable[0] = 1 to IRQ_STATUS SHALL clear bit0; simultaneous new rising edge SHALL win (bit0 stays 1).
REQ-026 irqOut SHALL be register = IRQ_STATUS[0] AND IRQ_ENABLE[0], evaluated from next-state values (one cycle after the setting edge/write).
REQ-027 IRQ_ENABLE, IRQ_STATUS unused bits SHALL read 0.
REQ-028 coreCounterNIn SHALL equal the merge value whenever write targets N, else coreCounterN (no undriven/X outputs).

Reset
REQ-029 While reset = 0: readData = 0, readDataValid = 0, irqOut = 0, IRQ_STATUS = 0, IRQ_ENABLE = 0, coreIrqQ = 0, all We/Re = 0 regardless of bus inputs.
REQ-030 Reset asserted mid-access SHALL abort it: no readDataValid after release for a read issued before reset.
REQ-031 First access SHALL be accepted on the first rising edge with reset = 1.

Verification
REQ-032 Write addr0, data 32'h1234_5678, byteEnable 4'b1111 -> coreCounter1We pulse 1 cycle, coreCounter1In = 32'h1234_5678.
REQ-033 coreCounter2 = 32'hAABB_CCDD, write addr1, data 32'h0000_0011, byteEnable 4'b0001 -> coreCounter2In = 32'hAABB_CC11.
REQ-034 Read addr4 -> next cycle readDataValid = 1, readData = ID_VALUE; read addr6 -> readData = 0.
REQ-035 IRQ_ENABLE = 1, coreIrq 0->1 -> IRQ_STATUS = 1, irqOut = 1 next cycle; write addr2 data 1 -> both 0; coreIrq held high -> no re-set.
REQ-036 W1C on same cycle as coreIrq rising edge -> IRQ_STATUS stays 1; read + write together at addr0 -> We pulse, no readDataValid.
REQ-037 Read issued, reset asserted before next edge -> readDataValid stays 0 through and after reset release; all outputs at reset values.

Source files
------------

// File: rtl/core_bus_slave.sv
// core_bus_slave: register-mapped bus slave fronting a two-counter core.
//
// Word map: 0 COUNTER1 (RW), 1 COUNTER2 (RW), 2 IRQ_STATUS (bit0, W1C),
//           3 IRQ_ENABLE (bit0, RW), 4 ID (RO), 5-7 reserved (read 0).
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   address/read/write    bus access, one per cycle; write wins over read
//   writeData/byteEnable  write data with per-byte qualifiers
//   readData/Valid        registered read data, valid one cycle after the read
//   irqOut                registered IRQ_STATUS[0] & IRQ_ENABLE[0]
//   coreCounterN*         load value, write/read strobes and live value per counter
//   coreIrq               level interrupt from the counter core
module core_bus_slave #(
    parameter logic [31:0] ID_VALUE = 32'hC0DE_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writeData,
    input  logic [3:0]  byteEnable,
    output logic [31:0] readData,
    output logic        readDataValid,
    output logic        irqOut,
    output logic [31:0] coreCounter1In,
    output logic [31:0] coreCounter2In,
    output logic        coreCounter1We,
    output logic        coreCounter2We,
    output logic        coreCounter1Re,
    output logic        coreCounter2Re,
    input  logic [31:0] coreCounter1,
    input  logic [31:0] coreCounter2,
    input  logic        coreIrq
);

    logic [31:0] read_data_q;
    logic        read_valid_q;
    logic        irq_out_q;
    logic        irq_status_q;
    logic        irq_status_d;
    logic        irq_enable_q;
    logic        irq_enable_d;
    logic        core_irq_q;

    logic        rd_acc;
    logic        wr_c1;
    logic        wr_c2;
    logic        irq_rise;
    logic        w1c;
    logic [31:0] be_mask;
    logic [31:0] rd_mux;

    // A simultaneous write turns the access into a write only.
    assign rd_acc = read & ~write;
    assign wr_c1  = write & (address == 3'd0);
    assign wr_c2  = write & (address == 3'd1);

    assign be_mask = {{8{byteEnable[3]}}, {8{byteEnable[2]}},
                      {8{byteEnable[1]}}, {8{byteEnable[0]}}};

    // Unselected counters are handed back their own value so the core never sees X.
    assign coreCounter1In = wr_c1 ? ((writeData & be_mask) | (coreCounter1 & ~be_mask))
                                  : coreCounter1;
    assign coreCounter2In = wr_c2 ? ((writeData & be_mask) | (coreCounter2 & ~be_mask))
                                  : coreCounter2;

    // Strobes are forced low while reset is asserted, whatever the bus does.
    assign coreCounter1We = reset & wr_c1;
    assign coreCounter2We = reset & wr_c2;
    assign coreCounter1Re = reset & rd_acc & (address == 3'd0);
    assign coreCounter2Re = reset & rd_acc & (address == 3'd1);

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            3'd0:    rd_mux = coreCounter1;
            3'd1:    rd_mux = coreCounter2;
            3'd2:    rd_mux = {31'h0, irq_status_q};
            3'd3:    rd_mux = {31'h0, irq_enable_q};
            3'd4:    rd_mux = ID_VALUE;
            default: rd_mux = 32'h0;
        endcase
    end

    assign irq_rise = coreIrq & ~core_irq_q;
    assign w1c      = write & (address == 3'd2) & byteEnable[0] & writeData[0];

    // A new rising edge beats a same-cycle clear.
    assign irq_status_d = irq_rise | (irq_status_q & ~w1c);
    assign irq_enable_d = (write && address == 3'd3 && byteEnable[0]) ? writeData[0]
                                                                      : irq_enable_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q  <= 32'h0;
            read_valid_q <= 1'b0;
            irq_out_q    <= 1'b0;
            irq_status_q <= 1'b0;
            irq_enable_q <= 1'b0;
            core_irq_q   <= 1'b0;
        end else begin
            read_valid_q <= rd_acc;
            if (rd_acc) begin
                read_data_q <= rd_mux;
            end
            irq_status_q <= irq_status_d;
            irq_enable_q <= irq_enable_d;
            core_irq_q   <= coreIrq;
            irq_out_q    <= irq_status_d & irq_enable_d;
        end
    end

    assign readData      = read_data_q;
    assign readDataValid = read_valid_q;
    assign irqOut        = irq_out_q;

endmodule

// File: tb/tb_core_bus_slave.sv
// Bench for core_bus_slave: directed vector table, IRQ/reset sequences and a
// randomized run checked against a behavioural register-map model.
module tb_core_bus_slave;

    localparam logic [31:0] ID = 32'hC0DE_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read, write;
    logic [31:0] writeData;
    logic [3:0]  byteEnable;
    logic [31:0] readData;
    logic        readDataValid, irqOut;
    logic [31:0] coreCounter1In, coreCounter2In;
    logic        coreCounter1We, coreCounter2We, coreCounter1Re, coreCounter2Re;
    logic [31:0] coreCounter1, coreCounter2;
    logic        coreIrq;

    core_bus_slave #(.ID_VALUE(ID)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writeData(writeData), .byteEnable(byteEnable), .readData(readData),
        .readDataValid(readDataValid), .irqOut(irqOut),
        .coreCounter1In(coreCounter1In), .coreCounter2In(coreCounter2In),
        .coreCounter1We(coreCounter1We), .coreCounter2We(coreCounter2We),
        .coreCounter1Re(coreCounter1Re), .coreCounter2Re(coreCounter2Re),
        .coreCounter1(coreCounter1), .coreCounter2(coreCounter2), .coreIrq(coreIrq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endfunction

    // Behavioural model of the register map.
    logic        m_status, m_enable, m_prev_irq, m_valid, m_irq_out;
    logic [31:0] m_rdata;

    function automatic void model_reset();
        m_status = 0; m_enable = 0; m_prev_irq = 0; m_valid = 0; m_irq_out = 0;
        m_rdata = 0;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] cur, logic [31:0] wd, logic [3:0] be);
        logic [31:0] res = cur;
        for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
        return res;
    endfunction

    // One bus cycle: drive, check strobes mid-cycle, clock, check registered outputs.
    task automatic step(input logic [2:0] a, input logic r, input logic w,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] c1, input logic [31:0] c2, input logic irq,
                        output logic [5:0] strobes, output logic [31:0] in1,
                        output logic [31:0] in2);
        logic        is_rd;
        logic        wr1, wr2;
        logic [31:0] rv;
        address = a; read = r; write = w; writeData = wd; byteEnable = be;
        coreCounter1 = c1; coreCounter2 = c2; coreIrq = irq;
        is_rd = r && !w;
        wr1 = w && a == 0;
        wr2 = w && a == 1;
        #2;
        strobes = {coreCounter1We, coreCounter2We, coreCounter1Re, coreCounter2Re, 2'b00};
        in1 = coreCounter1In;
        in2 = coreCounter2In;
        chk("we1", coreCounter1We, wr1);
        chk("we2", coreCounter2We, wr2);
        chk("re1", coreCounter1Re, is_rd && a == 0);
        chk("re2", coreCounter2Re, is_rd && a == 1);
        chk("in1", coreCounter1In, wr1 ? merge(c1, wd, be) : c1);
        chk("in2", coreCounter2In, wr2 ? merge(c2, wd, be) : c2);
        @(posedge clk);
        if (is_rd) begin
            case (a)
                0: rv = c1;
                1: rv = c2;
                2: rv = {31'h0, m_status};
                3: rv = {31'h0, m_enable};
                4: rv = ID;
                default: rv = 0;
            endcase
            m_rdata = rv;
        end
        m_valid = is_rd;
        if (w && a == 2 && be[0] && wd[0]) m_status = 0;
        if (irq && !m_prev_irq) m_status = 1;
        if (w && a == 3 && be[0]) m_enable = wd[0];
        m_prev_irq = irq;
        m_irq_out = m_status && m_enable;
        #1;
        chk("rvalid", readDataValid, m_valid);
        chk("rdata", readData, m_rdata);
        chk("irqout", irqOut, m_irq_out);
    endtask

    typedef struct {
        logic [2:0]  a;
        logic        r, w;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] c1, c2;
        logic [3:0]  e_str;   // {we1, we2, re1, re2}
        logic [31:0] e_in1, e_in2;
        logic        e_valid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vec[12];
    logic [5:0]  s;
    logic [31:0] i1, i2;
    logic        irq_r;

    initial begin
        vec[0]  = '{3'd0, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 32'hAABB_CCDD,
                    4'b1000, 32'h1234_5678, 32'hAABB_CCDD, 1'b0, 32'h0};
        vec[1]  = '{3'd1, 1'b0, 1'b1, 32'h0000_0011, 4'h1, 32'h5555_5555, 32'hAABB_CCDD,
                    4'b0100, 32'h5555_5555, 32'hAABB_CC11, 1'b0, 32'h0};
        vec[2]  = '{3'd4, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0,
                    4'b0000, 32'h0, 32'h0, 1'b1, ID};
        vec[3]  = '{3'd6, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0,
                    4'b0000, 32'h0, 32'h0, 1'b1, 32'h0};
        vec[4]  = '{3'd0, 1'b1, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'h0,
                    4'b0010, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vec[5]  = '{3'd1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0102_0304,
                    4'b0001, 32'h0, 32'h0102_0304, 1'b1, 32'h0102_0304};
        vec[6]  = '{3'd4, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h1, 32'h2,
                    4'b0000, 32'h1, 32'h2, 1'b0, 32'h0102_0304};
        vec[7]  = '{3'd0, 1'b1, 1'b1, 32'h0000_00AA, 4'h1, 32'h1122_3344, 32'h0,
                    4'b1000, 32'h1122_33AA, 32'h0, 1'b0, 32'h0102_0304};
        vec[8]  = '{3'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'hCAFE_F00D, 32'h0,
                    4'b1000, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0102_0304};
        vec[9]  = '{3'd2, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0,
                    4'b0000, 32'h0, 32'h0, 1'b1, 32'h0};
        vec[10] = '{3'd3, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 32'h0,
                    4'b0000, 32'h0, 32'h0, 1'b0, 32'h0};
        vec[11] = '{3'd7, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0,
                    4'b0000, 32'h0, 32'h0, 1'b0, 32'h0};

        reset = 0; address = 0; read = 0; write = 1; writeData = 32'hFFFF_FFFF;
        byteEnable = 4'hF; coreCounter1 = 0; coreCounter2 = 0; coreIrq = 0;
        model_reset();
        #12;
        chk("rst_rdata", readData, 0);
        chk("rst_rvalid", readDataValid, 0);
        chk("rst_irqout", irqOut, 0);
        chk("rst_we1", coreCounter1We, 0);
        write = 0;
        @(posedge clk); #1;
        reset = 1;

        // Directed table.
        foreach (vec[k]) begin
            step(vec[k].a, vec[k].r, vec[k].w, vec[k].wd, vec[k].be, vec[k].c1, vec[k].c2,
                 1'b0, s, i1, i2);
            chk($sformatf("vec%0d_str", k), {28'h0, s[5:2]}, {28'h0, vec[k].e_str});
            chk($sformatf("vec%0d_in1", k), i1, vec[k].e_in1);
            chk($sformatf("vec%0d_in2", k), i2, vec[k].e_in2);
            chk($sformatf("vec%0d_valid", k), readDataValid, vec[k].e_valid);
            chk($sformatf("vec%0d_rdata", k), readData, vec[k].e_rdata);
        end

        // IRQ set, W1C, held level, then clear colliding with a new edge.
        step(3, 0, 1, 32'h1, 4'h1, 0, 0, 0, s, i1, i2);
        step(0, 0, 0, 0, 0, 0, 0, 1, s, i1, i2);
        chk("irq_set", irqOut, 1);
        step(2, 1, 0, 0, 0, 0, 0, 1, s, i1, i2);
        chk("irq_status_rd", readData, 1);
        step(2, 0, 1, 32'h1, 4'h1, 0, 0, 1, s, i1, i2);
        chk("irq_w1c", irqOut, 0);
        step(2, 1, 0, 0, 0, 0, 0, 1, s, i1, i2);
        chk("irq_held_no_reset", readData, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, s, i1, i2);
        step(2, 0, 1, 32'h1, 4'h1, 0, 0, 1, s, i1, i2);
        chk("irq_edge_wins", irqOut, 1);
        step(4, 1, 0, 0, 0, 0, 0, 1, s, i1, i2);

        // Reset during an outstanding read.
        address = 4; read = 1; write = 0;
        #2;
        reset = 0;
        model_reset();
        address = 0; write = 1;
        #1;
        chk("mid_rst_we1", coreCounter1We, 0);
        chk("mid_rst_re", {31'h0, coreCounter1Re | coreCounter2Re}, 0);
        chk("mid_rst_irqout", irqOut, 0);
        @(posedge clk); #1;
        chk("mid_rst_rvalid", readDataValid, 0);
        chk("mid_rst_rdata", readData, 0);
        write = 0; read = 0;
        reset = 1;
        step(0, 0, 0, 0, 0, 0, 0, 0, s, i1, i2);
        chk("post_rst_rvalid", readDataValid, 0);

        // Randomized run against the model.
        irq_r = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) irq_r = ~irq_r;
            step(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom,
                 4'($urandom), $urandom, $urandom, irq_r, s, i1, i2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
